// File: rtl/alu_pkg.sv
// Shared definitions for the GCD sequencer and its combinational ALU:
// ALU command encodings, data width and the sequencer state encoding.
package alu_pkg;

    localparam int DATA_W = 16;

    localparam logic [2:0] MODE_BIGGER  = 3'd0;
    localparam logic [2:0] MODE_SMALLER = 3'd1;
    localparam logic [2:0] MODE_MODULO  = 3'd2;
    localparam logic [2:0] MODE_IDLE    = 3'd3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MAX   = 3'd1,
        S_MIN   = 3'd2,
        S_CHECK = 3'd3,
        S_MOD   = 3'd4,
        S_DONE  = 3'd5
    } gcd_state_t;

endpackage

// File: rtl/gcd_alu.sv
// Combinational ALU shared with the GCD sequencer: bigger, smaller and modulo.
module gcd_alu
    import alu_pkg::*;
(
    input  logic [2:0]        mode_i,
    input  logic [DATA_W-1:0] op_a_i,
    input  logic [DATA_W-1:0] op_b_i,
    output logic [DATA_W-1:0] res_o
);

    always_comb begin
        res_o = '0;
        case (mode_i)
            MODE_BIGGER:  res_o = (op_a_i > op_b_i) ? op_a_i : op_b_i;
            MODE_SMALLER: res_o = (op_a_i < op_b_i) ? op_a_i : op_b_i;
            // The sequencer never divides by zero; return the dividend so the output stays defined.
            MODE_MODULO:  res_o = (op_b_i == '0) ? op_a_i : (op_a_i % op_b_i);
            default:      res_o = '0;
        endcase
    end

endmodule

// File: rtl/gcd_top.sv
// Wrapper pairing the GCD sequencer with its dedicated ALU instance.
// With GCD_CTRL_ITER_CNT_EN defined the iteration count is exposed as iter_cnt_o.
module gcd_top
    import alu_pkg::*;
#(
    parameter  int MAX_ITER = 24,
    localparam int ITER_W   = $clog2(MAX_ITER + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              ready_o,
    output logic [DATA_W-1:0] gcd_o,
    output logic              err_o,
    output logic              valid_o,
    input  logic              res_ready_i
`ifdef GCD_CTRL_ITER_CNT_EN
    ,
    output logic [ITER_W-1:0] iter_cnt_o
`endif
);

    logic [2:0]        alu_mode;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] alu_res;

    gcd_ctrl #(
        .MAX_ITER(MAX_ITER)
    ) u_ctrl (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .a_i        (a_i),
        .b_i        (b_i),
        .ready_o    (ready_o),
        .gcd_o      (gcd_o),
        .err_o      (err_o),
        .valid_o    (valid_o),
        .res_ready_i(res_ready_i),
        .alu_mode_o (alu_mode),
        .op_a_o     (op_a),
        .op_b_o     (op_b),
        .alu_res_i  (alu_res)
`ifdef GCD_CTRL_ITER_CNT_EN
        ,
        .iter_cnt_o (iter_cnt_o)
`endif
    );

    gcd_alu u_alu (
        .mode_i (alu_mode),
        .op_a_i (op_a),
        .op_b_i (op_b),
        .res_o  (alu_res)
    );

endmodule

// File: rtl/gcd_ctrl.sv
// Euclid GCD sequencer driving an external combinational ALU, one operation per cycle.
// Optional GCD_CTRL_ITER_CNT_EN adds iter_cnt_o reporting the final modulo-iteration count.
module gcd_ctrl
    import alu_pkg::*;
#(
    parameter  int MAX_ITER = 24,
    localparam int ITER_W   = $clog2(MAX_ITER + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              ready_o,
    output logic [DATA_W-1:0] gcd_o,
    output logic              err_o,
    output logic              valid_o,
    input  logic              res_ready_i,
    output logic [2:0]        alu_mode_o,
    output logic [DATA_W-1:0] op_a_o,
    output logic [DATA_W-1:0] op_b_o,
    input  logic [DATA_W-1:0] alu_res_i
`ifdef GCD_CTRL_ITER_CNT_EN
    ,
    output logic [ITER_W-1:0] iter_cnt_o
`endif
);

    gcd_state_t        state_reg, state_next;
    logic [DATA_W-1:0] a_reg, a_next;
    logic [DATA_W-1:0] b_reg, b_next;
    logic [DATA_W-1:0] x_reg, x_next;
    logic [DATA_W-1:0] y_reg, y_next;
    logic [ITER_W-1:0] iter_reg, iter_next;
    logic [DATA_W-1:0] gcd_reg, gcd_next;
    logic              err_reg, err_next;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= S_IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            x_reg     <= '0;
            y_reg     <= '0;
            iter_reg  <= '0;
            gcd_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            x_reg     <= x_next;
            y_reg     <= y_next;
            iter_reg  <= iter_next;
            gcd_reg   <= gcd_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        x_next     = x_reg;
        y_next     = y_reg;
        iter_next  = iter_reg;
        gcd_next   = gcd_reg;
        err_next   = err_reg;
        alu_mode_o = MODE_IDLE;
        op_a_o     = '0;
        op_b_o     = '0;
        ready_o    = 1'b0;
        valid_o    = 1'b0;

        case (state_reg)
            S_IDLE: begin
                ready_o = 1'b1;
                if (start_i) begin
                    a_next     = a_i;
                    b_next     = b_i;
                    iter_next  = '0;
                    state_next = S_MAX;
                end
            end
            S_MAX: begin
                alu_mode_o = MODE_BIGGER;
                op_a_o     = a_reg;
                op_b_o     = b_reg;
                x_next     = alu_res_i;
                state_next = S_MIN;
            end
            S_MIN: begin
                alu_mode_o = MODE_SMALLER;
                op_a_o     = a_reg;
                op_b_o     = b_reg;
                y_next     = alu_res_i;
                state_next = S_CHECK;
            end
            S_CHECK: begin
                // x is the larger operand, so x==0 means both inputs were zero.
                if (x_reg == '0) begin
                    gcd_next   = '0;
                    err_next   = 1'b1;
                    state_next = S_DONE;
                end else if (y_reg == '0) begin
                    gcd_next   = x_reg;
                    err_next   = 1'b0;
                    state_next = S_DONE;
                end else if (iter_reg == ITER_W'(MAX_ITER)) begin
                    gcd_next   = '0;
                    err_next   = 1'b1;
                    state_next = S_DONE;
                end else begin
                    state_next = S_MOD;
                end
            end
            S_MOD: begin
                alu_mode_o = MODE_MODULO;
                op_a_o     = x_reg;
                op_b_o     = y_reg;
                x_next     = y_reg;
                y_next     = alu_res_i;
                iter_next  = iter_reg + ITER_W'(1);
                state_next = S_CHECK;
            end
            S_DONE: begin
                valid_o = 1'b1;
                // A start in the same cycle is deliberately not accepted here.
                if (res_ready_i) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign gcd_o = gcd_reg;
    assign err_o = err_reg;

`ifdef GCD_CTRL_ITER_CNT_EN
    logic [ITER_W-1:0] iter_cnt_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            iter_cnt_reg <= '0;
        end else if (state_reg == S_CHECK && state_next == S_DONE) begin
            iter_cnt_reg <= iter_reg;
        end
    end

    assign iter_cnt_o = iter_cnt_reg;
`endif

endmodule
